// File: rtl/cpu_io_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Definitions shared by the CPU output path: default word/byte widths used by
// the CPU top, the serializer state encoding and a helper that derives the
// number of bytes per word.
// -----------------------------------------------------------------------------
package cpu_io_pkg;

  // Defaults shared with the CPU top so both sides agree on the word format.
  localparam int unsigned CPU_WIDTH     = 24;
  localparam int unsigned CPU_BYTEWIDTH = 8;

  // Serializer FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Bytes emitted per CPU word (WIDTH is a multiple of BYTEWIDTH).
  function automatic int unsigned calc_nbytes(input int unsigned width,
                                              input int unsigned bytewidth);
    return width / bytewidth;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through read data.
//
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   rst_ni    asynchronous active-low reset (clears pointers and count)
//   push_i    write request; accepted when not full, or when full and a pop
//             happens on the same edge
//   wdata_i   data written on an accepted push
//   pop_i     read request; ignored when empty
//   rdata_o   word at the head of the FIFO (valid when !empty_o)
//   count_o   number of words held (0..DEPTH)
//   full_o    FIFO holds DEPTH words
//   empty_o   FIFO holds no words
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PTRWIDTH = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    rdata_o,
  output logic [PTRWIDTH:0]   count_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTRWIDTH-1:0] wr_ptr_q;
  logic [PTRWIDTH-1:0] rd_ptr_q;
  logic [PTRWIDTH:0]   count_q;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (count_q == (PTRWIDTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when a pop frees the head slot on the
  // same edge; the pop reads the old head before the write lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap modulo DEPTH by natural overflow (DEPTH = 2**PTRWIDTH).
      if (do_push) wr_ptr_q <= wr_ptr_q + PTRWIDTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTRWIDTH'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (PTRWIDTH+1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (PTRWIDTH+1)'(1);
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the count and pointers
  // define which entries are meaningful, so stale contents are never read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cpu_out_serializer.sv
// -----------------------------------------------------------------------------
// cpu_out_serializer
// Captures CPU output words (out while outFlag=1) into a FIFO and emits each
// word MSB-first as a byte stream over a valid/ready handshake.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset; discards buffered and partial words
//   outFlag    CPU output strobe, one cycle per word
//   out        CPU output word, valid while outFlag=1
//   byteData   current byte toward the consumer (stable while stalled)
//   byteValid  byteData is valid
//   byteReady  consumer accepts byteData this cycle
//   fifoCount  words held in the FIFO (0..DEPTH)
//   empty      FIFO holds no words
//   overflow   sticky: a word arrived while the FIFO was full and was dropped
//   busy       FIFO non-empty or serializer not idle
// -----------------------------------------------------------------------------
module cpu_out_serializer
  import cpu_io_pkg::*;
#(
  parameter int unsigned WIDTH     = CPU_WIDTH,
  parameter int unsigned BYTEWIDTH = CPU_BYTEWIDTH,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTRWIDTH  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 outFlag,
  input  logic [WIDTH-1:0]     out,
  output logic [BYTEWIDTH-1:0] byteData,
  output logic                 byteValid,
  input  logic                 byteReady,
  output logic [PTRWIDTH:0]    fifoCount,
  output logic                 empty,
  output logic                 overflow,
  output logic                 busy
);

  localparam int unsigned NBYTES   = calc_nbytes(WIDTH, BYTEWIDTH);
  localparam int unsigned IDXW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

  ser_state_e       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [IDXW-1:0]  idx_q;
  logic             overflow_q;

  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             load_w;
  logic             drop_w;

  sync_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .PTRWIDTH (PTRWIDTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (outFlag),
    .wdata_i (out),
    .pop_i   (load_w),
    .rdata_o (fifo_head),
    .count_o (fifoCount),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A new word is loaded (and popped) either from IDLE, or in SEND when the
  // last byte of the current word is accepted -- that second case gives
  // back-to-back words with no bubble. The registered empty flag is used, so a
  // push on the same edge is only seen on the following edge.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_w = 1'b0;
    if (!fifo_empty) begin
      if (state_q == IDLE) begin
        load_w = 1'b1;
      end else if (byteReady && (idx_q == '0)) begin
        load_w = 1'b1;
      end
    end
  end

  // Drop only when full and no pop frees a slot on this edge.
  assign drop_w = outFlag && fifo_full && !load_w;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drop_w) overflow_q <= 1'b1;

      if (load_w) begin
        shreg_q <= fifo_head;
        idx_q   <= IDX_LAST;
        state_q <= SEND;
      end else if ((state_q == SEND) && byteReady) begin
        if (idx_q != '0) begin
          shreg_q <= shreg_q << BYTEWIDTH;
          idx_q   <= idx_q - IDXW'(1);
        end else begin
          state_q <= IDLE;
        end
      end
      // With byteReady=0 nothing changes, which keeps byteData stable.
    end
  end

  assign byteData  = shreg_q[WIDTH-1 -: BYTEWIDTH];
  assign byteValid = (state_q == SEND);
  assign empty     = fifo_empty;
  assign overflow  = overflow_q;
  assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_cpu_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_cpu_out_serializer
// Directed bench: each pushed word adds its bytes to an expected-byte queue;
// every accepted byte (byteValid && byteReady before an edge) is popped and
// compared. Status outputs are checked at directed points.
// -----------------------------------------------------------------------------
module tb_cpu_out_serializer;

  localparam int unsigned WIDTH     = 24;
  localparam int unsigned BYTEWIDTH = 8;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned PTRWIDTH  = 3;

  logic                 clock;
  logic                 reset;
  logic                 outFlag;
  logic [WIDTH-1:0]     out;
  logic [BYTEWIDTH-1:0] byteData;
  logic                 byteValid;
  logic                 byteReady;
  logic [PTRWIDTH:0]    fifoCount;
  logic                 empty;
  logic                 overflow;
  logic                 busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  cpu_out_serializer #(
    .WIDTH     (WIDTH),
    .BYTEWIDTH (BYTEWIDTH),
    .DEPTH     (DEPTH),
    .PTRWIDTH  (PTRWIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .outFlag   (outFlag),
    .out       (out),
    .byteData  (byteData),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .fifoCount (fifoCount),
    .empty     (empty),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the byte transferred at the coming edge, then advance to
  // just after the edge where outputs are sampled and inputs are driven.
  task automatic step();
    logic [7:0] exp_b;
    if (byteValid && byteReady) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra_byte observed=%0h expected=none", byteData);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        chk("sb_byte", 32'(byteData), 32'(exp_b));
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Present a word for one edge; keep_it=0 for a word expected to be dropped.
  task automatic send_word(input logic [23:0] w, input bit keep_it);
    outFlag = 1'b1;
    out     = w;
    if (keep_it) begin
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    step();
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !byteValid) break;
      step();
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_valid"}, 32'(byteValid), 32'd0);
  endtask

  initial begin
    int vcnt;
    reset     = 1'b0;
    outFlag   = 1'b0;
    out       = '0;
    byteReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    chk("rst_valid", 32'(byteValid), 32'd0);
    chk("rst_data",  32'(byteData),  32'd0);
    chk("rst_count", 32'(fifoCount), 32'd0);
    chk("rst_empty", 32'(empty),     32'd1);
    chk("rst_ovf",   32'(overflow),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    reset = 1'b1;
    step();

    // Single word, latency and byte order
    byteReady = 1'b1;
    send_word(24'h015F90, 1'b1);
    outFlag = 1'b0;
    chk("lat_cap_valid", 32'(byteValid), 32'd0);
    chk("lat_cap_count", 32'(fifoCount), 32'd1);
    step();
    chk("lat_load_valid", 32'(byteValid), 32'd1);
    chk("lat_load_data",  32'(byteData),  32'h01);
    drain("single", 20);
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_busy",  32'(busy),  32'd0);

    // Back-to-back words, no bubble
    send_word(24'h02BF20, 1'b1);
    send_word(24'h000050, 1'b1);
    outFlag = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (byteValid) vcnt++;
      else if (vcnt > 0) break;
      step();
    end
    chk("b2b_run_len", 32'(vcnt), 32'd6);
    drain("b2b", 20);

    // Backpressure mid-word
    send_word(24'h015F90, 1'b1);
    outFlag = 1'b0;
    step();
    step();
    byteReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(byteValid), 32'd1);
      chk("bp_data",  32'(byteData),  32'h5F);
    end
    byteReady = 1'b1;
    drain("bp", 20);
    chk("pre_ovf", 32'(overflow), 32'd0);

    // Overflow: words 1..10 with the consumer stalled, word 10 dropped
    byteReady = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      send_word(24'(i), i <= 9);
    end
    outFlag = 1'b0;
    chk("ovf_count", 32'(fifoCount), 32'd8);
    chk("ovf_flag",  32'(overflow),  32'd1);
    chk("ovf_head",  32'(byteData),  32'h00);
    byteReady = 1'b1;
    drain("ovf", 200);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_empty",  32'(empty),    32'd1);

    // Reset during the second byte of a word with three words queued
    byteReady = 1'b0;
    send_word(24'hA1A2A3, 1'b1);
    send_word(24'hB1B2B3, 1'b1);
    send_word(24'hC1C2C3, 1'b1);
    send_word(24'hD1D2D3, 1'b1);
    outFlag   = 1'b0;
    byteReady = 1'b1;
    step();
    chk("mid_data",  32'(byteData),  32'hA2);
    chk("mid_count", 32'(fifoCount), 32'd3);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(byteValid), 32'd0);
    chk("arst_count", 32'(fifoCount), 32'd0);
    chk("arst_empty", 32'(empty),     32'd1);
    chk("arst_busy",  32'(busy),      32'd0);
    chk("arst_data",  32'(byteData),  32'd0);
    chk("arst_ovf",   32'(overflow),  32'd0);
    exp_q.delete();
    step();
    step();
    reset = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (byteValid) vcnt++;
      step();
    end
    chk("no_stale_bytes", 32'(vcnt), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
